// File: rtl/apb_payload_controller.sv
// APB slave for ERR_STATUS / PAYLOAD0..1 / DATA_SIZE that streams the stored payload as bytes.
// Optional build macro APB_WAIT_STATE_EN inserts one wait cycle between setup and access.
module apb_payload_controller #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel_x,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [2:0]            paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_last,
  output logic                  busy
);
  localparam int unsigned MAX_BYTES = 2 * DATA_WIDTH / 8;
  localparam int unsigned SIZE_W    = $clog2(MAX_BYTES + 1);
  localparam int unsigned IDX_W     = $clog2(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} apb_state_t;

  apb_state_t              state;
  logic [DATA_WIDTH-1:0]   payload0;
  logic [DATA_WIDTH-1:0]   payload1;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [SIZE_W-1:0]       data_size;
  logic [3:0]              err_sticky;
  logic [3:0]              err_q;
  logic [3:0]              err_nxt;
  logic [2:0]              addr_q;
  logic                    write_q;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_inc;
  logic [2*DATA_WIDTH-1:0] payload_w;
  logic [DATA_WIDTH-1:0]   rd_val;
  logic                    setup;
  logic                    size_bad;
  logic                    last_nxt;
  logic [7:0]              byte_nxt;
`ifdef APB_WAIT_STATE_EN
  logic [DATA_WIDTH-1:0]   rd_q;
`endif

  // Error and read data are both resolved from the setup-cycle view of the bus.
  always_comb begin
    setup    = (state == IDLE) && psel_x && !penable;
    size_bad = (pwdata == '0) || (pwdata > DATA_WIDTH'(MAX_BYTES));
    err_nxt  = '0;
    err_nxt[0] = paddr[2];
    if (pwrite) begin
      err_nxt[1] = (paddr == 3'd0);
      err_nxt[2] = busy && !paddr[2] && (paddr != 3'd0);
      err_nxt[3] = (paddr == 3'd3) && size_bad;
    end
    rd_val = '0;
    if (!pwrite) begin
      case (paddr)
        3'd0:    rd_val = DATA_WIDTH'({busy, err_sticky});
        3'd1:    rd_val = payload0;
        3'd2:    rd_val = payload1;
        3'd3:    rd_val = DATA_WIDTH'(data_size);
        default: rd_val = '0;
      endcase
    end
    payload_w = {payload1, payload0};
    idx_inc   = idx + 1'b1;
    byte_nxt  = payload_w[{idx_inc, 3'b000} +: 8];
    last_nxt  = ((SIZE_W'(idx_inc) + SIZE_W'(1)) == data_size);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state      <= IDLE;
      prdata     <= '0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      tx_last    <= 1'b0;
      busy       <= 1'b0;
      payload0   <= '0;
      payload1   <= '0;
      wdata_q    <= '0;
      data_size  <= '0;
      err_sticky <= '0;
      err_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      idx        <= '0;
`ifdef APB_WAIT_STATE_EN
      rd_q       <= '0;
`endif
    end else begin
      if (tx_valid && tx_ready) begin
        if (tx_last) begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          idx      <= '0;
          tx_data  <= '0;
          tx_last  <= 1'b0;
        end else begin
          idx     <= idx_inc;
          tx_data <= byte_nxt;
          tx_last <= last_nxt;
        end
      end

      case (state)
        IDLE: begin
          if (setup) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            err_q   <= err_nxt;
`ifdef APB_WAIT_STATE_EN
            rd_q    <= rd_val;
            state   <= WAIT;
`else
            prdata  <= rd_val;
            pready  <= 1'b1;
            pslverr <= |err_nxt;
            state   <= ACCESS;
`endif
          end
        end
`ifdef APB_WAIT_STATE_EN
        WAIT: begin
          prdata  <= rd_q;
          pready  <= 1'b1;
          pslverr <= |err_q;
          state   <= ACCESS;
        end
`endif
        ACCESS: begin
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          state   <= IDLE;
          // A freshly reported error survives the clear-on-read of ERR_STATUS.
          err_sticky <= (((!write_q) && (addr_q == 3'd0)) ? 4'b0000 : err_sticky) | err_q;
          if (write_q && (err_q == '0)) begin
            case (addr_q)
              3'd1: payload0 <= wdata_q;
              3'd2: payload1 <= wdata_q;
              3'd3: begin
                data_size <= wdata_q[SIZE_W-1:0];
                busy      <= 1'b1;
                tx_valid  <= 1'b1;
                idx       <= '0;
                tx_data   <= payload_w[7:0];
                tx_last   <= (wdata_q[SIZE_W-1:0] == SIZE_W'(1));
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
